// File: rtl/cache_assoc_pkg.sv
// Shared defaults, derived address-field widths and controller state encoding
// for the set-associative cache.
package cache_assoc_pkg;
  localparam int CACHE_WAYS       = 2;
  localparam int CACHE_SETS       = 64;
  localparam int CACHE_LINE_WORDS = 4;

  localparam int CACHE_IDX_W = $clog2(CACHE_SETS);
  localparam int CACHE_OFF_W = $clog2(CACHE_LINE_WORDS);
  localparam int CACHE_TAG_W = 32 - CACHE_IDX_W - CACHE_OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RF} state_e;

  // Width of a field that must be at least one bit even when it encodes one value.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty/tag per set plus a line of data words.
// Single write port sharing the read index; reads are combinational.
module cache_way #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = 6,
  parameter int OFF_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [OFF_W-1:0] word,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_data_en,
  input  logic [31:0]      wr_data,
  input  logic             wr_meta_en,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic [TAG_W-1:0] wr_tag
);
  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_meta_en) begin
      valid_d[idx] = wr_valid;
      dirty_d[idx] = wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags and data are only trusted behind valid, so they skip reset.
  always_ff @(posedge clk) begin
    if (wr_meta_en) tag_q[idx] <= wr_tag;
    if (wr_data_en) data_q[idx][word] <= wr_data;
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx][word];
endmodule

// File: rtl/cache_assoc.sv
// Write-back, write-allocate set-associative cache between an sbus master
// and an sram-like memory port; round-robin victim per set.
module cache_assoc
  import cache_assoc_pkg::*;
#(
  parameter int WAYS       = CACHE_WAYS,
  parameter int SETS       = CACHE_SETS,
  parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sbus_en,
  input  logic        sbus_we,
  input  logic [1:0]  sbus_size,
  input  logic [31:0] sbus_addr,
  input  logic [31:0] sbus_data_w,
  output logic [31:0] sbus_data_r,
  output logic        sbus_stall,
  output logic        sram_like_req,
  output logic        sram_like_wr,
  output logic [1:0]  sram_like_size,
  output logic [31:0] sram_like_addr,
  output logic [31:0] sram_like_wdata,
  input  logic [31:0] sram_like_rdata,
  input  logic        sram_like_addr_ok,
  input  logic        sram_like_data_ok
);
  localparam int IDX_W    = $clog2(SETS);
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int OFF_W    = width_min1(LINE_WORDS);
  localparam int TAG_W    = 32 - IDX_W - OFF_BITS - 2;
  localparam int WP_W     = width_min1(WAYS);

  state_e                     state_q, state_d;
  logic [OFF_W-1:0]           cnt_q, cnt_d;
  logic [WP_W-1:0]            victim_q, victim_d;
  logic                       acc_q, acc_d;
  logic [SETS-1:0][WP_W-1:0]  vptr_q, vptr_d;
  logic [31:0]                data_r_q, data_r_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_word;
  assign req_tag  = sbus_addr[31 -: TAG_W];
  assign req_idx  = sbus_addr[2+OFF_BITS +: IDX_W];
  assign req_word = OFF_W'((sbus_addr >> 2) & 32'(LINE_WORDS - 1));

  logic [WAYS-1:0]             w_valid, w_dirty, hit_vec, w_data_en, w_meta_en;
  logic [WAYS-1:0][TAG_W-1:0]  w_tag;
  logic [WAYS-1:0][31:0]       w_data;
  logic [OFF_W-1:0]            way_word;
  logic [31:0]                 way_wr_data;
  logic                        way_wr_dirty;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (req_idx),
      .word      (way_word),
      .rd_valid  (w_valid[w]),
      .rd_dirty  (w_dirty[w]),
      .rd_tag    (w_tag[w]),
      .rd_data   (w_data[w]),
      .wr_data_en(w_data_en[w]),
      .wr_data   (way_wr_data),
      .wr_meta_en(w_meta_en[w]),
      .wr_valid  (1'b1),
      .wr_dirty  (way_wr_dirty),
      .wr_tag    (req_tag)
    );
    assign hit_vec[w] = w_valid[w] && (w_tag[w] == req_tag);
  end

  logic            hit;
  logic [WP_W-1:0] hit_way, pick;
  logic            found;
  assign hit = |hit_vec;

  // Lowest-index invalid way wins; otherwise fall back to the set's pointer.
  always_comb begin
    hit_way = '0;
    pick    = vptr_q[req_idx];
    found   = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WP_W'(w);
      if (!w_valid[w] && !found) begin
        pick  = WP_W'(w);
        found = 1'b1;
      end
    end
  end

  // Write data arrives right-aligned; shift it into its byte lanes.
  logic [3:0]  be;
  logic [31:0] wsh, merged;
  always_comb begin
    be     = (sbus_size == 2'b00) ? 4'b0001 : (sbus_size == 2'b01) ? 4'b0011 : 4'b1111;
    be     = be << sbus_addr[1:0];
    wsh    = sbus_data_w << {sbus_addr[1:0], 3'b000};
    merged = w_data[hit_way];
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wsh[8*b +: 8];
  end

  logic last, xfer_done;
  assign last = (cnt_q == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    victim_d      = victim_q;
    acc_d         = acc_q;
    vptr_d        = vptr_q;
    data_r_d      = data_r_q;
    w_data_en     = '0;
    w_meta_en     = '0;
    way_wr_data   = sram_like_rdata;
    way_wr_dirty  = 1'b0;
    way_word      = cnt_q;
    sbus_stall    = 1'b0;
    sram_like_req = 1'b0;
    sram_like_wr  = 1'b0;
    xfer_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        way_word = req_word;
        if (sbus_en) begin
          if (hit) begin
            if (sbus_we) begin
              w_data_en[hit_way] = 1'b1;
              w_meta_en[hit_way] = 1'b1;
              way_wr_dirty       = 1'b1;
              way_wr_data        = merged;
            end else begin
              data_r_d = w_data[hit_way] >> {sbus_addr[1:0], 3'b000};
            end
          end else begin
            sbus_stall = 1'b1;
            victim_d   = pick;
            cnt_d      = '0;
            acc_d      = 1'b0;
            state_d    = (w_valid[pick] && w_dirty[pick]) ? S_WB : S_RF;
          end
        end
      end
      default: begin
        sbus_stall    = 1'b1;
        sram_like_req = !acc_q;
        sram_like_wr  = (state_q == S_WB);
        // data_ok only counts once this transfer's address has been taken.
        xfer_done     = sram_like_data_ok && (acc_q || sram_like_addr_ok);
        if (sram_like_req && sram_like_addr_ok && !sram_like_data_ok) acc_d = 1'b1;
        if (xfer_done) begin
          acc_d = 1'b0;
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (state_q == S_RF) w_data_en[victim_q] = 1'b1;
          if (last) begin
            if (state_q == S_WB) begin
              state_d = S_RF;
            end else begin
              w_meta_en[victim_q] = 1'b1;
              vptr_d[req_idx]     = (vptr_q[req_idx] == WP_W'(WAYS - 1)) ? '0
                                                                         : vptr_q[req_idx] + 1'b1;
              state_d             = S_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= '0;
      acc_q    <= 1'b0;
      vptr_q   <= '0;
      data_r_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      acc_q    <= acc_d;
      vptr_q   <= vptr_d;
      data_r_q <= data_r_d;
    end
  end

  logic [TAG_W-1:0] bus_tag;
  assign bus_tag         = (state_q == S_WB) ? w_tag[victim_q] : req_tag;
  assign sram_like_addr  = (32'(bus_tag) << (IDX_W + OFF_BITS + 2)) |
                           (32'(req_idx) << (OFF_BITS + 2)) | (32'(cnt_q) << 2);
  assign sram_like_wdata = w_data[victim_q];
  assign sram_like_size  = 2'b10;
  assign sbus_data_r     = data_r_q;
endmodule

// File: tb/tb_cache_assoc.sv
// Randomized scoreboard bench for cache_assoc: flat-memory reference model,
// per-set tag model predicting hits, write-backs and bus address order.
module tb_cache_assoc;
  import cache_assoc_pkg::*;
  localparam int WAYS = CACHE_WAYS, SETS = CACHE_SETS, LW = CACHE_LINE_WORDS;
  localparam int LINE_B = LW * 4;
  localparam int MEMW = 4096;

  logic clk = 1'b0, rst = 1'b1;
  logic sbus_en = 1'b0, sbus_we = 1'b0;
  logic [1:0] sbus_size = 2'b10;
  logic [31:0] sbus_addr = '0, sbus_data_w = '0, sbus_data_r;
  logic sbus_stall, sram_like_req, sram_like_wr;
  logic [1:0] sram_like_size;
  logic [31:0] sram_like_addr, sram_like_wdata;
  logic [31:0] sram_like_rdata = '0;
  logic sram_like_addr_ok = 1'b0, sram_like_data_ok = 1'b0;

  always #5 clk = ~clk;

  cache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .sbus_en(sbus_en), .sbus_we(sbus_we), .sbus_size(sbus_size),
    .sbus_addr(sbus_addr), .sbus_data_w(sbus_data_w), .sbus_data_r(sbus_data_r),
    .sbus_stall(sbus_stall), .sram_like_req(sram_like_req), .sram_like_wr(sram_like_wr),
    .sram_like_size(sram_like_size), .sram_like_addr(sram_like_addr),
    .sram_like_wdata(sram_like_wdata), .sram_like_rdata(sram_like_rdata),
    .sram_like_addr_ok(sram_like_addr_ok), .sram_like_data_ok(sram_like_data_ok));

  int n_cmp = 0, n_bad = 0;
  logic [31:0] smem [MEMW];
  logic [31:0] rmem [MEMW];
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_vptr  [SETS];

  typedef struct {
    logic rd; logic [31:0] data; logic miss; logic wb;
    logic [31:0] wb_base; logic [31:0] rf_base;
  } exp_t;
  exp_t sbq[$];
  logic [32:0] bus_log[$];
  bit mon_en = 1'b0;
  logic [31:0] last_rd = '0;
  int rst_epoch = 0;
  bit k_fix = 1'b0, k_same = 1'b0;
  int k_dly = 0, k_ddly = 0;

  always @(posedge clk) if (rst) rst_epoch <= rst_epoch + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; end
    end
    for (int i = 0; i < MEMW; i++) rmem[i] = smem[i];
  endtask

  // Architectural result from a flat memory; line placement from the policy rules.
  task automatic model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic [31:0] wd, output exp_t e);
    int ai, idx, tg, hw, v, nb, lane;
    ai = int'(a); idx = (ai / LINE_B) % SETS; tg = ai / (LINE_B * SETS); hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    e.rd = !we; e.miss = (hw < 0); e.wb = 1'b0; e.wb_base = '0; e.data = '0;
    e.rf_base = 32'(ai - ai % LINE_B);
    if (hw < 0) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!m_valid[idx][w] && v < 0) v = w;
      if (v < 0) v = m_vptr[idx];
      e.wb = m_valid[idx][v] && m_dirty[idx][v];
      e.wb_base = 32'(m_tag[idx][v] * LINE_B * SETS + idx * LINE_B);
      m_valid[idx][v] = 1; m_dirty[idx][v] = 0; m_tag[idx][v] = tg;
      m_vptr[idx] = (m_vptr[idx] + 1) % WAYS;
      hw = v;
    end
    if (we) begin
      m_dirty[idx][hw] = 1;
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int b = 0; b < nb; b++) begin
        lane = ai % 4 + b;
        rmem[ai / 4][8*lane +: 8] = wd[8*b +: 8];
      end
    end else begin
      e.data = rmem[ai / 4] >> (8 * (ai % 4));
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic [31:0] wd);
    exp_t e; int n;
    model(a, we, sz, wd, e);
    sbq.push_back(e);
    @(negedge clk);
    sbus_en = 1'b1; sbus_we = we; sbus_size = sz; sbus_addr = a; sbus_data_w = wd;
    #1; n = 0;
    while (sbus_stall && n < 500) begin @(negedge clk); #1; n++; end
    if (n >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: addr %h still stalled after %0d cycles", a, n);
      finish_run();
    end
    @(negedge clk);
    sbus_en = 1'b0;
  endtask

  // Memory slave with randomized (or pinned) addr_ok / data_ok latency.
  task automatic serve();
    int d, dd, hold, ep; logic [31:0] a, wd; logic w; bit same;
    d    = k_fix ? k_dly : int'($urandom_range(0, 3));
    same = k_fix ? k_same : bit'($urandom_range(0, 1));
    dd   = k_fix ? k_ddly : int'($urandom_range(0, 2));
    a = sram_like_addr; w = sram_like_wr; wd = sram_like_wdata; hold = 1;
    chk("bus_size", 64'(sram_like_size), 64'(2));
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (!sram_like_req) return;
      hold++;
    end
    if (k_fix) chk("req_hold", 64'(hold), 64'(k_dly + 1));
    ep = rst_epoch;
    sram_like_addr_ok = 1'b1;
    if (!same) begin
      @(negedge clk);
      sram_like_addr_ok = 1'b0;
      repeat (dd) @(negedge clk);
    end
    sram_like_data_ok = 1'b1;
    sram_like_rdata = smem[a[13:2]];
    if (ep == rst_epoch) begin
      chk("bus_stable", {31'd0, sram_like_wr, sram_like_addr}, {31'd0, w, a});
      if (w) begin
        chk("wdata_stable", 64'(sram_like_wdata), 64'(wd));
        smem[a[13:2]] = wd;
      end
      bus_log.push_back({w, a});
    end
    @(negedge clk);
    sram_like_addr_ok = 1'b0;
    sram_like_data_ok = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sram_like_req && !rst) serve();
    end
  end

  // Monitor: pops one expectation per completed sbus request.
  initial begin
    bit st; exp_t e; int nb; logic [32:0] x;
    st = 0;
    forever begin
      @(negedge clk); #2;
      if (!mon_en) begin st = 0; continue; end
      if (sbus_en && sbus_stall) st = 1;
      else if (sbus_en) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: completion at addr %h with no expectation", sbus_addr);
        end else begin
          e = sbq.pop_front();
          @(posedge clk); #1;
          chk("miss", 64'(st), 64'(e.miss));
          nb = (e.wb ? LW : 0) + (e.miss ? LW : 0);
          chk("bus_xfers", 64'(bus_log.size()), 64'(nb));
          if (bus_log.size() == nb)
            for (int i = 0; i < nb; i++) begin
              if (e.wb && i < LW) x = {1'b1, e.wb_base + 32'(4 * i)};
              else x = {1'b0, e.rf_base + 32'(4 * (e.wb ? i - LW : i))};
              chk("bus_order", 64'(bus_log[i]), 64'(x));
            end
          bus_log.delete();
          if (e.rd) begin
            chk("rdata", 64'(sbus_data_r), 64'(e.data));
            last_rd = e.data;
          end else begin
            chk("data_r_hold", 64'(sbus_data_r), 64'(last_rd));
          end
        end
        st = 0;
      end
    end
  end

  initial begin
    #3000000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    int n; logic [31:0] a, wd; logic [1:0] sz; logic we;
    for (int i = 0; i < MEMW; i++) smem[i] = $urandom;
    smem[32'h1000 >> 2] = 32'hDEADBEEF;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 64'(sbus_stall), 64'(0));
    chk("rst_req", 64'(sram_like_req), 64'(0));
    chk("rst_data_r", 64'(sbus_data_r), 64'(0));
    mon_en = 1'b1;

    do_req(32'h1000, 1'b0, 2'b10, '0);            // cold read: 4 refills
    do_req(32'h1000, 1'b1, 2'b10, 32'h11223344);  // word write hit
    do_req(32'h1001, 1'b1, 2'b00, 32'h000000AB);  // byte write hit
    do_req(32'h1000, 1'b0, 2'b10, '0);            // expect 1122AB44
    do_req(32'h1400, 1'b1, 2'b10, 32'hCAFEF00D);  // second way of set 0, dirty
    do_req(32'h1800, 1'b0, 2'b10, '0);            // evict dirty way 0
    do_req(32'h1404, 1'b0, 2'b10, '0);            // hit on way 1
    k_fix = 1'b1; k_dly = 3; k_same = 1'b1; k_ddly = 0;
    do_req(32'h1C00, 1'b0, 2'b10, '0);            // slow addr_ok, combined data_ok
    do_req(32'h1002, 1'b0, 2'b01, '0);

    // Reset while the second refill word is in flight.
    k_dly = 1; k_same = 1'b0; k_ddly = 2;
    mon_en = 1'b0;
    @(negedge clk);
    sbus_en = 1'b1; sbus_we = 1'b0; sbus_size = 2'b10; sbus_addr = 32'h2040;
    n = 0;
    do begin @(negedge clk); #3; n++; end while (bus_log.size() < 1 && n < 200);
    chk("rst_wait_first_word", 64'(bus_log.size() >= 1), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; sbus_en = 1'b0;
    @(negedge clk); #1;
    chk("midrst_req", 64'(sram_like_req), 64'(0));
    chk("midrst_stall", 64'(sbus_stall), 64'(0));
    chk("midrst_data_r", 64'(sbus_data_r), 64'(0));
    rst = 1'b0;
    model_reset();
    bus_log.delete();
    last_rd = '0;
    mon_en = 1'b1;
    do_req(32'h2040, 1'b0, 2'b10, '0);            // must miss and refill fully
    k_fix = 1'b0;

    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = 32'h1000 + 32'($urandom_range(0, 4)) * 32'h400 + 32'($urandom_range(0, 3)) * 16
        + 32'($urandom_range(0, 3)) * 4;
      if (sz == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
      else if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_req(a, we, sz, wd);
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    finish_run();
  end
endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-002 Parameter SETS, default 64, sets per way (power of two).
REQ-003 Parameter LINE_WORDS, default 4, 32-bit words per line (power of two, 1..16).
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 sbus_en  in  1  request valid; sbus_we  in  1  write; sbus_size  in  2  00 byte / 01 half / 10 word; sbus_addr  in  32  byte address; sbus_data_w  in  32  write data.
REQ-007 sbus_data_r  out  32  registered read data, right-shifted by addr[1:0]; sbus_stall  out  1  request not yet complete.
REQ-008 sram_like_req  out  1; sram_like_wr  out  1; sram_like_size  out  2 (always 10); sram_like_addr  out  32; sram_like_wdata  out  32; sram_like_rdata  in  32; sram_like_addr_ok  in  1; sram_like_data_ok  in  1.

Function
REQ-009 Address split {tag, index = log2(SETS) bits, word offset = log2(LINE_WORDS) bits, byte[1:0]}.
REQ-010 Per way/set: valid, dirty, tag, LINE_WORDS data words; per set: victim pointer, log2(WAYS) bits.
REQ-011 Hit = any way valid with matching tag; at most one way hits.
REQ-012 States IDLE, WB, RF; IDLE holds while no miss.
REQ-013 IDLE read hit: sbus_stall=0; sbus_data_r updated at the next clock edge.
REQ-014 IDLE write hit: sbus_stall=0; merge bytes per size/addr[1:0] into hit word at the edge; set dirty.
REQ-015 IDLE miss, either direction: sbus_stall=1 same cycle; latch victim = invalid way with lowest index, else way at victim pointer; go WB if victim valid&dirty, else RF.
REQ-016 WB: write LINE_WORDS words, word 0 first, addr {victim tag, index, word, 00}, wr=1; then RF.
REQ-017 RF: read LINE_WORDS words, word 0 first, addr {req tag, index, word, 00}, wr=0; each data_ok writes word into victim; after last, set valid, tag; dirty=0; advance victim pointer mod WAYS; go IDLE.
REQ-018 Write miss is write-allocate: after refill, the request completes as a hit in IDLE on the next cycle.
REQ-019 Read miss completes one cycle after last refill data_ok, via the IDLE hit path; stall low that cycle.
REQ-020 Handshake: req asserted until the cycle of addr_ok inclusive; next word's req not before data_ok of the previous; one outstanding transfer maximum.
REQ-021 addr/wr/wdata stable from req rise to data_ok.
REQ-022 Word counter, log2(LINE_WORDS) bits, zeroed on entry to WB/RF; wraps to zero exactly at last word.
REQ-023 addr_ok and data_ok in the same cycle: accepted as one complete transfer.
REQ-024 sbus inputs are held stable by the master while sbus_stall=1; sbus_en=0 in IDLE: no state change.
REQ-025 sbus_data_r holds its value while no read completes.

Reset
REQ-026 On rst: state IDLE; all valid, dirty, and victim pointers 0; counter 0; sbus_data_r 0; sram_like_req 0; sbus_stall 0 the following cycle.
REQ-027 rst mid-WB/RF: transfer abandoned; late data_ok after rst is ignored; data arrays need not be cleared.

Structure
REQ-028 Package includes gains CACHE_WAYS, CACHE_SETS, CACHE_LINE_WORDS defaults and tag/index/offset width macros derived from them.
REQ-029 One sub-module cache_way (tag/valid/dirty/data array for one way, one write port, async read); instantiated WAYS times.
REQ-030 Control FSM, victim select, byte merge in cache_assoc.

Verification
REQ-031 Cold read 0x00001000 with memory word 0xDEADBEEF: 4 reads at 0x1000..0x100C; stall until the cycle after 4th data_ok; data_r=0xDEADBEEF.
REQ-032 Byte write 0xAB to 0x00001001 after a fill with 0x11223344: no stall; read back 0x1000 -> 0x1122AB44.
REQ-033 Dirty line in set 0 both ways; access third tag in set 0: 4 writes of victim (way 0) before 4 reads; victim pointer becomes 1.
REQ-034 addr_ok delayed 3 cycles and data_ok asserted with addr_ok: req held 4 cycles; counter and data correct.
REQ-035 rst asserted during 2nd RF word: next cycle req=0, stall=0; rereading the same address misses and refills fully.
REQ-036 Read hit on way 1 while way 0 holds another tag in the same set: zero stall; correct data; no bus traffic.
